// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame shape, default divider and FSM states.
package uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 2604;
    localparam int FRAME_BITS       = 10;

    typedef enum logic {
        IDLE,
        XMIT
    } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and pulses shift on the terminal count.
import uart_pkg::*;

module uart_baud_cnt #(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic shift
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] count;

    assign shift = enable && (count == TERM);

    // Wraps to zero on the terminal count so each bit period is exactly BAUD_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= shift ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on trmt in IDLE and shifts a 10-bit frame out on TX.
import uart_pkg::*;

module uart_tx #(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    tx_state_t             state;
    tx_state_t             next_state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [3:0]            bit_cnt;
    logic                  shift;
    logic                  last_bit;
    logic                  load;
    logic                  baud_en;
    logic                  finish;

    uart_baud_cnt #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (load),
        .enable(baud_en),
        .shift (shift)
    );

    assign last_bit = (bit_cnt == 4'(FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (trmt) next_state = XMIT;
            XMIT: if (shift && last_bit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        baud_en = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: load = trmt;
            XMIT: begin
                baud_en = 1'b1;
                finish  = shift && last_bit;
            end
            default: ;
        endcase
    end

    // After ten shifts the register is all ones again, so TX idles high straight from the flop.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            shift_reg <= '1;
            bit_cnt   <= '0;
            tx_done   <= 1'b0;
        end else if (load) begin
            shift_reg <= {1'b1, tx_data, 1'b0};
            bit_cnt   <= '0;
            tx_done   <= 1'b0;
        end else if (shift) begin
            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
            bit_cnt   <= last_bit ? bit_cnt : bit_cnt + 4'd1;
            if (finish) tx_done <= 1'b1;
        end
    end

    assign TX = shift_reg[0];

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a short-divider and a default-divider instance checked each cycle against a timestamp model.
`timescale 1ns/1ps

module tb_uart_tx;
    import uart_pkg::*;

    localparam int BD0 = 4;
    localparam int BD1 = DEFAULT_BAUD_DIV;

    logic       clk = 1'b0;
    logic       rst0, rst1, trmt0, trmt1;
    logic [7:0] data0, data1;
    logic       tx0, tx1, done0, done1;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    bit     armed    = 1'b0;

    bit         m_busy [2];
    longint     m_e0   [2];
    logic [7:0] m_data [2];
    bit         m_done [2];

    uart_tx #(.BAUD_DIV(BD0)) dut0 (
        .clk(clk), .rst_n(rst0), .trmt(trmt0), .tx_data(data0), .TX(tx0), .tx_done(done0)
    );

    uart_tx dut1 (
        .clk(clk), .rst_n(rst1), .trmt(trmt1), .tx_data(data1), .TX(tx1), .tx_done(done1)
    );

    always #5 clk = ~clk;

    function automatic int bd(int i);
        return (i == 0) ? BD0 : BD1;
    endfunction

    function automatic logic in_rst(int i);
        return (i == 0) ? rst0 : rst1;
    endfunction

    function automatic logic in_trmt(int i);
        return (i == 0) ? trmt0 : trmt1;
    endfunction

    function automatic logic [7:0] in_data(int i);
        return (i == 0) ? data0 : data1;
    endfunction

    // Model: a frame is just an accept timestamp plus a byte; the line value is looked up by elapsed time.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (in_rst(i)) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
            end else if (m_busy[i]) begin
                if ((cyc + 1 - m_e0[i]) == longint'(10 * bd(i))) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                end
            end else if (in_trmt(i)) begin
                m_busy[i] <= 1'b1;
                m_e0[i]   <= cyc + 1;
                m_data[i] <= in_data(i);
                m_done[i] <= 1'b0;
            end
        end
    end

    function automatic logic exp_tx(int i);
        logic [9:0] frame;
        logic [3:0] idx;
        if (!m_busy[i]) return 1'b1;
        frame = {1'b1, m_data[i], 1'b0};
        idx   = 4'((cyc - m_e0[i]) / longint'(bd(i)));
        return frame[idx];
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic t, input logic [7:0] d);
        if (idx == 0) begin
            trmt0 = t;
            data0 = d;
        end else begin
            trmt1 = t;
            data1 = d;
        end
    endtask

    task automatic wait_edge(input longint target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        longint     e0;
        logic [9:0] frame_b3;

        rst0 = 1'b1;
        rst1 = 1'b1;
        applyStimulus(0, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, 8'h00);

        fork
            forever begin
                @(negedge clk);
                if (armed) begin
                    checkOutput("model_tx0", tx0, exp_tx(0));
                    checkOutput("model_done0", done0, m_done[0]);
                    checkOutput("model_tx1", tx1, exp_tx(1));
                    checkOutput("model_done1", done1, m_done[1]);
                end
            end
            begin
                #1_000_000;
                $display("[TB] FAIL watchdog: simulation time limit reached at edge %0d", cyc);
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        // Reset for three edges, then idle with no request.
        wait_edge(1);
        armed = 1'b1;
        wait_edge(3);
        rst0 = 1'b0;
        rst1 = 1'b0;
        wait_edge(4);
        checkOutput("reset_tx0", tx0, 1'b1);
        checkOutput("reset_done0", done0, 1'b0);
        checkOutput("reset_tx1", tx1, 1'b1);
        checkOutput("reset_done1", done1, 1'b0);
        wait_edge(10);
        checkOutput("idle_tx0", tx0, 1'b1);
        checkOutput("idle_done0", done0, 1'b0);

        // One-cycle request of 0xB3 with a 4-cycle bit period.
        frame_b3 = 10'b11_0110_0110;
        applyStimulus(0, 1'b1, 8'hB3);
        e0 = cyc + 1;
        wait_edge(e0);
        applyStimulus(0, 1'b0, 8'hB3);
        for (int j = 0; j < 10; j++) begin
            wait_edge(e0 + 4 * j);
            checkOutput("b3_bit_first", tx0, frame_b3[j]);
            wait_edge(e0 + 4 * j + 3);
            checkOutput("b3_bit_last", tx0, frame_b3[j]);
        end
        wait_edge(e0 + 39);
        checkOutput("b3_done_early", done0, 1'b0);
        wait_edge(e0 + 40);
        checkOutput("b3_done_rise", done0, 1'b1);
        wait_edge(e0 + 50);
        checkOutput("b3_done_sticky", done0, 1'b1);
        checkOutput("b3_tx_idle", tx0, 1'b1);

        // Default divider, request held 50 cycles, data changed mid-frame.
        applyStimulus(1, 1'b1, 8'hC5);
        e0 = cyc + 1;
        wait_edge(e0 + 20);
        applyStimulus(1, 1'b1, 8'h00);
        wait_edge(e0 + 49);
        applyStimulus(1, 1'b0, 8'h00);
        wait_edge(e0 + 2603);
        checkOutput("c5_start_last", tx1, 1'b0);
        wait_edge(e0 + 2604);
        checkOutput("c5_bit0", tx1, 1'b1);
        wait_edge(e0 + 2 * 2604);
        checkOutput("c5_bit1", tx1, 1'b0);
        wait_edge(e0 + 26039);
        checkOutput("c5_done_early", done1, 1'b0);
        wait_edge(e0 + 26040);
        checkOutput("c5_done_rise", done1, 1'b1);
        wait_edge(e0 + 26045);
        checkOutput("c5_no_second", tx1, 1'b1);

        // Request held high: back-to-back frames of 0x28 with one idle cycle between them.
        applyStimulus(0, 1'b1, 8'h28);
        e0 = cyc + 1;
        wait_edge(e0 + 39);
        checkOutput("b2b_done_early", done0, 1'b0);
        wait_edge(e0 + 40);
        checkOutput("b2b_gap_done", done0, 1'b1);
        checkOutput("b2b_gap_tx", tx0, 1'b1);
        wait_edge(e0 + 41);
        checkOutput("b2b_next_done", done0, 1'b0);
        checkOutput("b2b_next_start", tx0, 1'b0);
        wait_edge(e0 + 41 + 16);
        checkOutput("b2b_next_bit3", tx0, 1'b1);
        wait_edge(e0 + 61);
        applyStimulus(0, 1'b0, 8'h28);
        wait_edge(e0 + 90);
        checkOutput("b2b_final_done", done0, 1'b1);

        // Reset during data bit 3 aborts the frame; a fresh frame then completes.
        applyStimulus(0, 1'b1, 8'h28);
        e0 = cyc + 1;
        wait_edge(e0);
        applyStimulus(0, 1'b0, 8'h28);
        wait_edge(e0 + 17);
        checkOutput("abort_bit3", tx0, 1'b1);
        rst0 = 1'b1;
        wait_edge(e0 + 18);
        rst0 = 1'b0;
        checkOutput("abort_tx", tx0, 1'b1);
        checkOutput("abort_done", done0, 1'b0);
        wait_edge(e0 + 60);
        checkOutput("abort_no_done", done0, 1'b0);
        applyStimulus(0, 1'b1, 8'h28);
        e0 = cyc + 1;
        wait_edge(e0);
        applyStimulus(0, 1'b0, 8'h28);
        wait_edge(e0 + 13);
        checkOutput("redo_bit2", tx0, 1'b0);
        wait_edge(e0 + 17);
        checkOutput("redo_bit3", tx0, 1'b1);
        wait_edge(e0 + 40);
        checkOutput("redo_done", done0, 1'b1);

        // Second request while done is set: done drops on the accept edge.
        wait_edge(e0 + 45);
        applyStimulus(0, 1'b1, 8'hFF);
        e0 = cyc + 1;
        wait_edge(e0);
        applyStimulus(0, 1'b0, 8'hFF);
        checkOutput("again_done_clr", done0, 1'b0);
        checkOutput("again_start", tx0, 1'b0);
        wait_edge(e0 + 39);
        checkOutput("again_done_early", done0, 1'b0);
        wait_edge(e0 + 40);
        checkOutput("again_done_rise", done0, 1'b1);
        wait_edge(e0 + 44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
